// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
//
// Operand-capture stage for the ALU logical units (AND/OR/XOR/NOT). Two
// operands are entered one after the other on a shared input bus. Each rising
// edge of the load strobe captures the bus into the next operand register:
// x first, then y. Once both operands are loaded, x and y are held stable and
// op_valid is raised. The downstream unit acknowledges with op_ack, and entry
// then restarts at x.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   din       in   WIDTH  shared operand input bus (switches)
//   load      in   1      load strobe (level); only its rising edge acts
//   clear     in   1      synchronous clear; aborts entry and zeroes operands
//   op_ack    in   1      downstream consumed x/y; only honoured in READY
//   x         out  WIDTH  registered operand x
//   y         out  WIDTH  registered operand y
//   op_valid  out  1      x and y are both loaded and stable
//   stage     out  2      current state: 00 LOAD_X, 01 LOAD_Y, 10 READY
// -----------------------------------------------------------------------------
module alu_operand_loader #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   input  logic             clear,
   input  logic             op_ack,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             op_valid,
   output logic [1:0]       stage
);

   typedef enum logic [1:0] {
      LOAD_X = 2'b00,
      LOAD_Y = 2'b01,
      READY  = 2'b10
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] x_nxt;
   logic [WIDTH-1:0] y_nxt;
   logic             valid_nxt;
   logic             load_d;
   logic             load_rise;

   // load_d resets to 0. A strobe that is already high when reset is released
   // therefore counts as a rise on the first clock edge.
   assign load_rise = load & ~load_d;
   assign stage     = state;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= LOAD_X;
         x        <= '0;
         y        <= '0;
         op_valid <= 1'b0;
         load_d   <= 1'b0;
      end else begin
         state    <= state_nxt;
         x        <= x_nxt;
         y        <= y_nxt;
         op_valid <= valid_nxt;
         // Keeps tracking during clear, so a load held through clear is not
         // seen as a fresh rise afterwards.
         load_d   <= load;
      end
   end

   // NOTE: every output of this block gets a default (hold) first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      valid_nxt = op_valid;

      if (clear) begin
         state_nxt = LOAD_X;
         x_nxt     = '0;
         y_nxt     = '0;
         valid_nxt = 1'b0;
      end else begin
         case (state)
            LOAD_X: begin
               if (load_rise) begin
                  x_nxt     = din;
                  state_nxt = LOAD_Y;
               end
            end
            LOAD_Y: begin
               if (load_rise) begin
                  y_nxt     = din;
                  valid_nxt = 1'b1;
                  state_nxt = READY;
               end
            end
            READY: begin
               // Operands are frozen here; a load edge is dropped. The ack
               // returns to LOAD_X but leaves x/y in place for the next capture
               // to overwrite.
               if (op_ack) begin
                  valid_nxt = 1'b0;
                  state_nxt = LOAD_X;
               end
            end
            default: begin
               // Unused encoding 11: recover to LOAD_X and keep the operands.
               state_nxt = LOAD_X;
               valid_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_loader
//
// Self-checking bench for alu_operand_loader (WIDTH=4). A table of per-cycle
// vectors drives the entry, handshake, held-load and clear behaviour. Each row
// holds the inputs for one cycle and the expected outputs after that edge.
// Hand-written sequences cover the asynchronous reset cases.
// -----------------------------------------------------------------------------
module tb_alu_operand_loader;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] din;
   logic             load;
   logic             clear;
   logic             op_ack;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             op_valid;
   logic [1:0]       stage;

   int n_compared   = 0;
   int n_mismatched = 0;

   alu_operand_loader #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .load     (load),
      .clear    (clear),
      .op_ack   (op_ack),
      .x        (x),
      .y        (y),
      .op_valid (op_valid),
      .stage    (stage)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             clear;
      logic             load;
      logic [WIDTH-1:0] din;
      logic             op_ack;
      logic [WIDTH-1:0] exp_x;
      logic [WIDTH-1:0] exp_y;
      logic             exp_valid;
      logic [1:0]       exp_stage;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [7:0] actual,
                        input logic [7:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic check_all(input string tag, input logic [WIDTH-1:0] ex,
                            input logic [WIDTH-1:0] ey, input logic ev,
                            input logic [1:0] es);
      check({tag, ".x"},        8'(x),        8'(ex));
      check({tag, ".y"},        8'(y),        8'(ey));
      check({tag, ".op_valid"}, 8'(op_valid), 8'(ev));
      check({tag, ".stage"},    8'(stage),    8'(es));
   endtask

   // Drive inputs on the falling edge, then sample 1 time unit after the
   // following rising edge.
   task automatic cycle(input logic c, input logic l, input logic [WIDTH-1:0] d,
                        input logic a);
      @(negedge clk);
      clear  = c;
      load   = l;
      din    = d;
      op_ack = a;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic c, input logic l,
                               input logic [WIDTH-1:0] d, input logic a,
                               input logic [WIDTH-1:0] ex,
                               input logic [WIDTH-1:0] ey,
                               input logic ev, input logic [1:0] es);
      vec_t v;
      v.clear = c; v.load = l; v.din = d; v.op_ack = a;
      v.exp_x = ex; v.exp_y = ey; v.exp_valid = ev; v.exp_stage = es;
      return v;
   endfunction

   initial begin
      //             clr ld  din    ack  x      y      v    stage
      vecs[0]  = mk(0, 1, 4'hA, 0, 4'hA, 4'h0, 0, 2'b01); // capture x
      vecs[1]  = mk(0, 0, 4'h5, 0, 4'hA, 4'h0, 0, 2'b01);
      vecs[2]  = mk(0, 1, 4'h5, 0, 4'hA, 4'h5, 1, 2'b10); // capture y, valid
      vecs[3]  = mk(0, 0, 4'h5, 0, 4'hA, 4'h5, 1, 2'b10);
      vecs[4]  = mk(0, 1, 4'h7, 0, 4'hA, 4'h5, 1, 2'b10); // READY: no overwrite
      vecs[5]  = mk(0, 0, 4'h7, 1, 4'hA, 4'h5, 0, 2'b00); // ack, x/y kept
      vecs[6]  = mk(0, 0, 4'h7, 1, 4'hA, 4'h5, 0, 2'b00); // ack ignored in LOAD_X
      vecs[7]  = mk(0, 1, 4'h3, 0, 4'h3, 4'h5, 0, 2'b01); // held load begins
      vecs[8]  = mk(0, 1, 4'h9, 0, 4'h3, 4'h5, 0, 2'b01);
      vecs[9]  = mk(0, 1, 4'h9, 0, 4'h3, 4'h5, 0, 2'b01);
      vecs[10] = mk(0, 1, 4'h9, 0, 4'h3, 4'h5, 0, 2'b01);
      vecs[11] = mk(0, 1, 4'h9, 0, 4'h3, 4'h5, 0, 2'b01);
      vecs[12] = mk(0, 0, 4'h9, 0, 4'h3, 4'h5, 0, 2'b01); // load falls
      vecs[13] = mk(0, 1, 4'hC, 0, 4'h3, 4'hC, 1, 2'b10); // fresh rise -> y
      vecs[14] = mk(0, 0, 4'hC, 0, 4'h3, 4'hC, 1, 2'b10);
      vecs[15] = mk(0, 1, 4'h2, 1, 4'h3, 4'hC, 0, 2'b00); // ack beats load
      vecs[16] = mk(0, 1, 4'h2, 0, 4'h3, 4'hC, 0, 2'b00); // still high: no rise
      vecs[17] = mk(0, 0, 4'h2, 0, 4'h3, 4'hC, 0, 2'b00);
      vecs[18] = mk(0, 1, 4'h6, 0, 4'h6, 4'hC, 0, 2'b01); // new x
      vecs[19] = mk(0, 0, 4'h6, 0, 4'h6, 4'hC, 0, 2'b01);
      vecs[20] = mk(1, 1, 4'hE, 0, 4'h0, 4'h0, 0, 2'b00); // clear beats load
      vecs[21] = mk(0, 1, 4'hE, 0, 4'h0, 4'h0, 0, 2'b00); // load_d tracked
      vecs[22] = mk(0, 0, 4'hE, 0, 4'h0, 4'h0, 0, 2'b00);
      vecs[23] = mk(0, 1, 4'h1, 0, 4'h1, 4'h0, 0, 2'b01);
      vecs[24] = mk(0, 0, 4'hF, 1, 4'h1, 4'h0, 0, 2'b01); // ack ignored in LOAD_Y

      rst_n = 1'b1; din = '0; load = 1'b0; clear = 1'b0; op_ack = 1'b0;

      // Reset asserted mid-cycle: outputs must clear with no clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check_all("reset_async", 4'h0, 4'h0, 1'b0, 2'b00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         cycle(vecs[i].clear, vecs[i].load, vecs[i].din, vecs[i].op_ack);
         check_all($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_y,
                   vecs[i].exp_valid, vecs[i].exp_stage);
      end

      // Normal entry, then the downstream OR of the operands.
      cycle(0, 1, 4'h5, 0);
      check_all("entry_y", 4'h1, 4'h5, 1'b1, 2'b10);
      cycle(0, 0, 4'h0, 1);
      cycle(0, 1, 4'hA, 0);
      cycle(0, 0, 4'hA, 0);
      cycle(0, 1, 4'h5, 0);
      check_all("entry_a5", 4'hA, 4'h5, 1'b1, 2'b10);
      check("or_result", 8'(x | y), 8'h0F);

      // Async reset while READY, released with load already high. The first
      // edge after release counts as a rise and captures x.
      @(negedge clk);
      load = 1'b1;
      din  = 4'h9;
      #2;
      rst_n = 1'b0;
      #1;
      check_all("reset_ready", 4'h0, 4'h0, 1'b0, 2'b00);
      @(posedge clk);
      #1;
      check_all("reset_hold", 4'h0, 4'h0, 1'b0, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all("post_reset_x", 4'h9, 4'h0, 1'b0, 2'b01);
      cycle(0, 1, 4'h4, 0);
      check_all("post_reset_held", 4'h9, 4'h0, 1'b0, 2'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_compared, n_mismatched);
      $finish;
   end

endmodule
